// File: rtl/pc_gen_if.sv
// pc_gen_if: connects the IF-stage program-counter generator to the pipeline.
//   Control in (driven by the pipeline):
//     stall_i, br_taken_i, br_target_i, trap_i, trap_vec_i, halt_i, resume_i
//   Status out (driven by pc_gen):
//     pc_o, npc_o, fetch_valid_o, redirect_pending_o, misalign_o, fetch_count_o
// The master modport is the pipeline side; the slave modport is pc_gen.
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic             br_taken_i;
    logic [XLEN-1:0]  br_target_i;
    logic             trap_i;
    logic [XLEN-1:0]  trap_vec_i;
    logic             halt_i;
    logic             resume_i;

    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  npc_o;
    logic             fetch_valid_o;
    logic             redirect_pending_o;
    logic             misalign_o;
    logic [CNT_W-1:0] fetch_count_o;

    modport master (
        output stall_i, br_taken_i, br_target_i, trap_i, trap_vec_i, halt_i, resume_i,
        input  pc_o, npc_o, fetch_valid_o, redirect_pending_o, misalign_o, fetch_count_o
    );

    modport slave (
        input  stall_i, br_taken_i, br_target_i, trap_i, trap_vec_i, halt_i, resume_i,
        output pc_o, npc_o, fetch_valid_o, redirect_pending_o, misalign_o, fetch_count_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter for the IF stage.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pc_gen_if slave port
//     stall_i/br_taken_i/br_target_i/trap_i/trap_vec_i/halt_i/resume_i in
//     pc_o (registered), npc_o (pc_o+STEP), fetch_valid_o, redirect_pending_o,
//     misalign_o (one-cycle pulse), fetch_count_o (valid fetches since reset)
// Next-PC priority in RUN: trap > halt/stall (hold, buffer branch) > branch >
// buffered redirect > sequential. A branch seen while the PC cannot move is
// kept in pend/pend_tgt and replayed once fetching continues.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              STEP       = 4,
    parameter int              ALIGN_BITS = 2,
    parameter int              CNT_W      = 32
) (
    input  logic    clk,
    input  logic    rst,
    pc_gen_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    localparam logic [XLEN-1:0] STEP_V   = XLEN'(STEP);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] x);
        return x & ~LOW_MASK;
    endfunction

    function automatic logic misaligned(input logic [XLEN-1:0] x);
        return |(x & LOW_MASK);
    endfunction

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] count_q;
    logic             fetch_valid;

    assign fetch_valid = (state_q == RUN) && !bus.stall_i && !pend_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        misalign_d = 1'b0;

        if (state_q == RUN) begin
            if (bus.trap_i) begin
                // Trap wins over everything, including a simultaneous halt,
                // which still takes effect on the state.
                pc_d       = align(bus.trap_vec_i);
                pend_d     = 1'b0;
                misalign_d = misaligned(bus.trap_vec_i);
                if (bus.halt_i) state_d = HALT;
            end else if (bus.halt_i || bus.stall_i) begin
                if (bus.halt_i) state_d = HALT;
                if (bus.br_taken_i) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = bus.br_target_i;
                end
            end else if (bus.br_taken_i) begin
                pc_d       = align(bus.br_target_i);
                pend_d     = 1'b0;
                misalign_d = misaligned(bus.br_target_i);
            end else if (pend_q) begin
                pc_d       = align(pend_tgt_q);
                pend_d     = 1'b0;
                misalign_d = misaligned(pend_tgt_q);
            end else begin
                pc_d = pc_q + STEP_V;
            end
        end else begin
            if (bus.br_taken_i) begin
                pend_d     = 1'b1;
                pend_tgt_d = bus.br_target_i;
            end
            if (bus.trap_i) begin
                pc_d       = align(bus.trap_vec_i);
                pend_d     = 1'b0;
                misalign_d = misaligned(bus.trap_vec_i);
                state_d    = RUN;
            end else if (bus.resume_i) begin
                state_d = RUN;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_VEC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            misalign_q <= misalign_d;
            if (fetch_valid) count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.pc_o               = pc_q;
    assign bus.npc_o              = pc_q + STEP_V;
    assign bus.fetch_valid_o      = fetch_valid;
    assign bus.redirect_pending_o = pend_q;
    assign bus.misalign_o         = misalign_q;
    assign bus.fetch_count_o      = count_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. Each scenario task drives a
// table of cycles; the expected PC/pend/misalign for every cycle is pushed to
// a scoreboard queue when the cycle is driven and popped after the edge.
module tb_pc_gen;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    typedef struct {
        logic            stall;
        logic            br;
        logic [XLEN-1:0] tgt;
        logic            trap;
        logic [XLEN-1:0] vec;
        logic            halt;
        logic            resume;
        logic            v;     // expected fetch_valid_o before the edge
        logic [XLEN-1:0] pc;    // expected pc_o after the edge
        logic            pend;  // expected redirect_pending_o after the edge
        logic            mis;   // expected misalign_o after the edge
    } row_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic            pend;
        logic            mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_gen #(.XLEN(XLEN), .RESET_VEC('0), .STEP(4), .ALIGN_BITS(2), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic row_t mk(logic stall, logic br, logic [XLEN-1:0] tgt,
                                logic trap, logic [XLEN-1:0] vec, logic halt,
                                logic resume, logic v, logic [XLEN-1:0] pc,
                                logic pend, logic mis);
        row_t r;
        r.stall = stall; r.br = br; r.tgt = tgt; r.trap = trap; r.vec = vec;
        r.halt = halt; r.resume = resume; r.v = v; r.pc = pc; r.pend = pend;
        r.mis = mis;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's inputs and record what the DUT must show after the edge.
    task automatic drive(input row_t r);
        exp_t e;
        bus.stall_i     = r.stall;
        bus.br_taken_i  = r.br;
        bus.br_target_i = r.tgt;
        bus.trap_i      = r.trap;
        bus.trap_vec_i  = r.vec;
        bus.halt_i      = r.halt;
        bus.resume_i    = r.resume;
        e.pc = r.pc; e.pend = r.pend; e.mis = r.mis;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle();
        bus.stall_i = 0; bus.br_taken_i = 0; bus.br_target_i = '0;
        bus.trap_i = 0; bus.trap_vec_i = '0; bus.halt_i = 0; bus.resume_i = 0;
    endtask

    // Runs a table: fetch_valid_o is checked before each edge, the popped
    // scoreboard entry and npc_o after it.
    task automatic run_table(input string name, input row_t rows[$]);
        exp_t e;
        foreach (rows[i]) begin
            drive(rows[i]);
            checks++;
            if (bus.fetch_valid_o !== rows[i].v) begin
                failures++;
                $display("FAIL %s[%0d] fetch_valid got=%b exp=%b", name, i, bus.fetch_valid_o, rows[i].v);
            end
            if (rows[i].v) exp_cnt++;
            tick();
            e = exp_q.pop_front();
            checks++;
            if (bus.pc_o !== e.pc) begin
                failures++;
                $display("FAIL %s[%0d] pc got=%h exp=%h", name, i, bus.pc_o, e.pc);
            end
            checks++;
            if (bus.redirect_pending_o !== e.pend) begin
                failures++;
                $display("FAIL %s[%0d] pend got=%b exp=%b", name, i, bus.redirect_pending_o, e.pend);
            end
            checks++;
            if (bus.misalign_o !== e.mis) begin
                failures++;
                $display("FAIL %s[%0d] misalign got=%b exp=%b", name, i, bus.misalign_o, e.mis);
            end
            checks++;
            if (bus.npc_o !== e.pc + 32'd4) begin
                failures++;
                $display("FAIL %s[%0d] npc got=%h exp=%h", name, i, bus.npc_o, e.pc + 32'd4);
            end
        end
        idle();
        checks++;
        if (bus.fetch_count_o !== CNT_W'(exp_cnt)) begin
            failures++;
            $display("FAIL %s fetch_count got=%0d exp=%0d", name, bus.fetch_count_o, exp_cnt);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #12;
        checks++;
        if (bus.pc_o !== 32'h0 || bus.npc_o !== 32'h4) begin
            failures++;
            $display("FAIL reset pc/npc got=%h/%h exp=0/4", bus.pc_o, bus.npc_o);
        end
        checks++;
        if (bus.fetch_count_o !== '0 || bus.redirect_pending_o !== 1'b0 || bus.misalign_o !== 1'b0) begin
            failures++;
            $display("FAIL reset status got cnt=%0d pend=%b mis=%b exp=0/0/0",
                     bus.fetch_count_o, bus.redirect_pending_o, bus.misalign_o);
        end
        checks++;
        if (bus.fetch_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL reset fetch_valid got=%b exp=1", bus.fetch_valid_o);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_free_run();
        row_t r[$];
        r.push_back(mk(0,0,0, 0,0, 0,0, 1, 32'h4, 0,0));
        r.push_back(mk(0,0,0, 0,0, 0,0, 1, 32'h8, 0,0));
        r.push_back(mk(0,0,0, 0,0, 0,0, 1, 32'hC, 0,0));
        run_table("free_run", r);
        checks++;
        if (bus.npc_o !== 32'h10) begin
            failures++;
            $display("FAIL free_run npc got=%h exp=10", bus.npc_o);
        end
    endtask

    task automatic test_stall_redirect();
        row_t r[$];
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h10,  0,0));
        // Branch buffered during a two-cycle stall, replayed on release.
        r.push_back(mk(1,1,32'h80, 0,0,       0,0, 0, 32'h10,  1,0));
        r.push_back(mk(1,0,0,      0,0,       0,0, 0, 32'h10,  1,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h80,  0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h84,  0,0));
        // Newer branch overwrites the buffered one.
        r.push_back(mk(1,1,32'h40, 0,0,       0,0, 0, 32'h84,  1,0));
        r.push_back(mk(1,1,32'h60, 0,0,       0,0, 0, 32'h84,  1,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h60,  0,0));
        // Trap beats branch and stall in the same cycle.
        r.push_back(mk(1,1,32'h80, 1,32'h100, 0,0, 0, 32'h100, 0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h104, 0,0));
        run_table("stall_redirect", r);
    endtask

    task automatic test_misalign();
        row_t r[$];
        r.push_back(mk(0,1,32'h83, 0,0,       0,0, 1, 32'h80,  0,1));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h84,  0,0));
        r.push_back(mk(0,0,0,      1,32'h102, 0,0, 1, 32'h100, 0,1));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h104, 0,0));
        // Misaligned target replayed from the pending buffer.
        r.push_back(mk(1,1,32'h4A, 0,0,       0,0, 0, 32'h104, 1,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h48,  0,1));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h4C,  0,0));
        run_table("misalign", r);
    endtask

    task automatic test_halt();
        row_t r[$];
        r.push_back(mk(0,1,32'h20, 0,0,       0,0, 1, 32'h20,  0,0));
        // Halt, hold, then halt+resume together: resume wins.
        r.push_back(mk(0,0,0,      0,0,       1,0, 1, 32'h20,  0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h20,  0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h20,  0,0));
        r.push_back(mk(0,0,0,      0,0,       1,1, 0, 32'h20,  0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h24,  0,0));
        // Branch on the halting edge is buffered and replayed after resume.
        r.push_back(mk(0,1,32'h50, 0,0,       1,0, 1, 32'h24,  1,0));
        r.push_back(mk(0,0,0,      0,0,       0,1, 0, 32'h24,  1,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h50,  0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h54,  0,0));
        // Trap while halted restarts fetching.
        r.push_back(mk(0,0,0,      0,0,       1,0, 1, 32'h54,  0,0));
        r.push_back(mk(0,0,0,      1,32'h200, 0,0, 0, 32'h200, 0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h204, 0,0));
        // Trap and halt together: trap loads, state still halts.
        r.push_back(mk(0,0,0,      1,32'h300, 1,0, 1, 32'h300, 0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 0, 32'h300, 0,0));
        r.push_back(mk(0,0,0,      0,0,       0,1, 0, 32'h300, 0,0));
        r.push_back(mk(0,0,0,      0,0,       0,0, 1, 32'h304, 0,0));
        run_table("halt", r);
    endtask

    task automatic test_wrap_and_reset();
        row_t r[$];
        r.push_back(mk(0,0,0,      1,32'hFFFF_FFF8, 0,0, 1, 32'hFFFF_FFF8, 0,0));
        r.push_back(mk(0,0,0,      0,0,             0,0, 1, 32'hFFFF_FFFC, 0,0));
        r.push_back(mk(0,0,0,      0,0,             0,0, 1, 32'h0,         0,0));
        r.push_back(mk(0,0,0,      0,0,             0,0, 1, 32'h4,         0,0));
        r.push_back(mk(1,1,32'h90, 0,0,             0,0, 0, 32'h4,         1,0));
        run_table("wrap", r);
        // Asynchronous reset mid-cycle discards the buffered redirect at once.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pc_o !== 32'h0 || bus.redirect_pending_o !== 1'b0 || bus.fetch_count_o !== '0) begin
            failures++;
            $display("FAIL async_reset got pc=%h pend=%b cnt=%0d exp pc=0 pend=0 cnt=0",
                     bus.pc_o, bus.redirect_pending_o, bus.fetch_count_o);
        end
        #2;
        rst = 1'b0;
        exp_cnt = 0;
        r.delete();
        r.push_back(mk(0,0,0, 0,0, 0,0, 1, 32'h4, 0,0));
        r.push_back(mk(0,0,0, 0,0, 0,0, 1, 32'h8, 0,0));
        run_table("after_reset", r);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_redirect();
        test_misalign();
        test_halt();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the IF stage of the pipelined CPU. Holds the fetch PC and selects the next PC from the trap vector, branch redirect, buffered redirect or sequential increment. It absorbs pipeline stalls and halt/resume without losing a redirect. It also reports fetch validity, redirect misalignment and a fetched-instruction count to the rest of the pipeline.

## Interface
- XLEN, 32, PC width in bits
- RESET_VEC, 0, PC value after reset
- STEP, 4, sequential increment in bytes
- ALIGN_BITS, 2, low PC bits forced to zero on every redirect
- CNT_W, 32, fetch counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  IF stall; hold the PC
- br_taken_i  in  1  branch/jump redirect request from EX
- br_target_i  in  XLEN  redirect target
- trap_i  in  1  exception/interrupt redirect
- trap_vec_i  in  XLEN  trap handler address
- halt_i  in  1  stop fetching
- resume_i  in  1  restart fetching
- pc_o  out  XLEN  current fetch PC (registered)
- npc_o  out  XLEN  pc_o+STEP (combinational, mod 2^XLEN)
- fetch_valid_o  out  1  pc_o is a valid fetch this cycle
- redirect_pending_o  out  1  buffered redirect waiting
- misalign_o  out  1  one-cycle flag: the last loaded target had nonzero low ALIGN_BITS
- fetch_count_o  out  CNT_W  number of valid fetches since reset

## Operation
- Two states: RUN and HALT. Internal regs: pend (1 bit), pend_tgt (XLEN).
- align(x) = x with bits [ALIGN_BITS-1:0] cleared. Every loaded target goes through align().
- RUN, per edge, highest priority first:
  1. trap_i: pc←align(trap_vec_i), pend←0.
  2. stall_i: pc holds. If br_taken_i, then pend←1 and pend_tgt←br_target_i; a newer branch overwrites the older one.
  3. br_taken_i: pc←align(br_target_i), pend←0.
  4. pend: pc←align(pend_tgt), pend←0.
  5. Otherwise pc←pc+STEP, wrapping mod 2^XLEN.
- RUN→HALT when halt_i=1 and trap_i=0. On that edge pc holds; a br_taken_i is buffered into pend as in rule 2.
- halt_i and trap_i in the same cycle: the trap loads pc, and the state still moves to HALT.
- HALT, per edge:
  - trap_i: pc←align(trap_vec_i), pend←0, state→RUN.
  - else resume_i: state→RUN, pc unchanged.
  - else pc holds.
  - br_taken_i in HALT is buffered into pend, same as rule 2.
- halt_i and resume_i both high in HALT: resume wins. Both high in RUN: halt wins.
- fetch_valid_o = (state==RUN) & ~stall_i & ~pend. This is combinational from the registers and stall_i.
- fetch_count_o increments by 1, wrapping, on every edge where fetch_valid_o=1.
- misalign_o←1 on any edge that loads a trap, branch or pend target whose raw low ALIGN_BITS ≠ 0. Otherwise it is 0 on the next edge.
- redirect_pending_o = pend.

## Timing
- Reset values (asynchronous, immediate): pc_o=RESET_VEC, state=RUN, pend=0, pend_tgt=0, misalign_o=0, fetch_count_o=0.
  - Consequences: npc_o=RESET_VEC+STEP and fetch_valid_o=1 once stall_i=0.
- Redirect latency: a target presented in cycle n appears on pc_o in cycle n+1.
- A buffered redirect appears on pc_o one cycle after stall_i deasserts.
- Reset mid-operation discards pend and any HALT state with no delayed effects.
- Wrap-around: pc=2^XLEN−STEP advances to 0 with no flag.
- Combinational paths: none from br_/trap_ inputs to outputs. The only combinational input path is stall_i → fetch_valid_o.

## Test plan
- Reset then 3 free-running cycles → pc_o = 0, 4, 8, C; fetch_count_o = 3; npc_o = 0x10.
- At pc=0x10, stall_i=1 for 2 cycles with br_taken_i=1 and br_target_i=0x80 in the first stall cycle.
  - During the stall: pc_o holds 0x10, redirect_pending_o=1, fetch_valid_o=0.
  - On release: pc_o=0x80, pend=0.
- Stall with two branches, targets 0x40 then 0x60 → after release pc_o=0x60.
- Same cycle trap_i (vec 0x100), br_taken_i (0x80) and stall_i → pc_o=0x100, pend=0. Separately, br_target_i=0x83 → pc_o=0x80 and misalign_o pulses for 1 cycle.
- halt_i at pc=0x20, hold 3 cycles, then resume_i → pc_o stays 0x20 and fetch_valid_o=0 while halted, fetch_count_o unchanged. After resume: 0x20, 0x24.
- Set pc near 0xFFFFFFF8 via trap, free run → pc_o = 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Assert rst while pend=1 → pend=0 and pc_o=RESET_VEC immediately.
